// File: rtl/rvb_pcpi_pkg.sv
// rvb_pcpi_pkg: shared types for the PCPI master/responder pair.
package rvb_pcpi_pkg;

    localparam int CYCLES_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
    } req_t;

    typedef struct packed {
        logic [31:0]         rd;
        logic                wr;
        logic                timeout;
        logic [CYCLES_W-1:0] cycles;
    } rsp_t;

endpackage

// File: rtl/rvb_pcpi_master.sv
// rvb_pcpi_master: issues one PCPI transaction per request and returns rd/wr/timeout/cycles.
// Timeout and the sticky claimed bit exist only with RVB_PCPI_MASTER_TIMEOUT_EN defined.
module rvb_pcpi_master
    import rvb_pcpi_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_insn,
    input  logic [31:0]         req_rs1,
    input  logic [31:0]         req_rs2,
    input  logic [31:0]         req_rs3,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rd,
    output logic                rsp_wr,
    output logic                rsp_timeout,
    output logic [CYCLES_W-1:0] rsp_cycles,
    output logic                pcpi_valid,
    output logic [31:0]         pcpi_insn,
    output logic [31:0]         pcpi_rs1,
    output logic [31:0]         pcpi_rs2,
    output logic [31:0]         pcpi_rs3,
    input  logic                pcpi_wr,
    input  logic [31:0]         pcpi_rd,
    input  logic                pcpi_wait,
    input  logic                pcpi_ready
);

    localparam logic [CYCLES_W-1:0] TO_LIM = CYCLES_W'(TIMEOUT);

    state_t              state, state_next;
    req_t                req_q;
    rsp_t                rsp_q;
    logic [CYCLES_W-1:0] cnt, cnt_inc;
    logic                accept, done, expire;

    assign req_ready   = state == IDLE && !reset;
    assign pcpi_valid  = state == ISSUE;
    assign rsp_valid   = state == RESP;
    assign accept      = req_valid && req_ready;
    assign done        = pcpi_valid && pcpi_ready;
    assign cnt_inc     = cnt == '1 ? cnt : cnt + 1'b1;
    assign {pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3} = req_q;
    assign {rsp_rd, rsp_wr, rsp_timeout, rsp_cycles} = rsp_q;

`ifdef RVB_PCPI_MASTER_TIMEOUT_EN
    logic claimed;
    // wait in the expiring cycle still claims the instruction, and ready always wins
    assign expire = pcpi_valid && !claimed && !pcpi_wait && !pcpi_ready && cnt_inc == TO_LIM;
    always_ff @(posedge clk) begin
        if (reset || accept) claimed <= 1'b0;
        else if (pcpi_valid && pcpi_wait) claimed <= 1'b1;
    end
`else
    logic unused;
    assign unused = ^{pcpi_wait, TO_LIM};
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? ISSUE : IDLE;
            ISSUE:   state_next = (done || expire) ? RESP : ISSUE;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
            rsp_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_q <= '{insn: req_insn, rs1: req_rs1, rs2: req_rs2, rs3: req_rs3};
                cnt   <= '0;
            end else if (pcpi_valid) begin
                cnt <= cnt_inc;
            end
            if (done)
                rsp_q <= '{rd: pcpi_rd, wr: pcpi_wr, timeout: 1'b0, cycles: cnt_inc};
            else if (expire)
                rsp_q <= '{rd: 32'd0, wr: 1'b0, timeout: 1'b1, cycles: cnt_inc};
        end
    end

endmodule

// File: tb/tb_rvb_pcpi_master.sv
// tb_rvb_pcpi_master: directed tests with a transaction-level model checked every cycle.
module tb_rvb_pcpi_master;

`ifdef RVB_PCPI_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
    logic        pcpi_wr = 1'b0, pcpi_wait = 1'b0, pcpi_ready = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        req_ready, rsp_valid, rsp_wr, rsp_timeout, pcpi_valid;
    logic [31:0] rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3;
    logic [7:0]  rsp_cycles;

    int n_cmp = 0, n_bad = 0;
    bit en = 1'b0;

    // model: phase 0 idle, 1 issuing, 2 responding
    int          ph = 0, n = 0;
    bit          cl = 1'b0;
    logic [31:0] e_insn, e_rs1, e_rs2, e_rs3, e_rd;
    logic        e_wr, e_to;
    int          e_cyc;

    always #5 clk = ~clk;

    rvb_pcpi_master #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
        .pcpi_valid(pcpi_valid),
        .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    function automatic int sat(input int v);
        return v >= 255 ? 255 : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) ph <= 0;
        else case (ph)
            0: if (req_valid) begin
                ph <= 1; n <= 0; cl <= 1'b0;
                e_insn <= req_insn; e_rs1 <= req_rs1; e_rs2 <= req_rs2; e_rs3 <= req_rs3;
            end
            1: begin
                n  <= sat(n);
                cl <= cl | pcpi_wait;
                if (pcpi_ready) begin
                    ph <= 2; e_rd <= pcpi_rd; e_wr <= pcpi_wr; e_to <= 1'b0; e_cyc <= sat(n);
                end else if (TO_EN && !cl && !pcpi_wait && sat(n) == 16) begin
                    ph <= 2; e_rd <= '0; e_wr <= 1'b0; e_to <= 1'b1; e_cyc <= sat(n);
                end
            end
            default: if (rsp_ready) ph <= 0;
        endcase
    end

    always @(negedge clk) if (en) begin
        chk("req_ready", 32'(req_ready), 32'(ph == 0 && !reset));
        chk("pcpi_valid", 32'(pcpi_valid), 32'(ph == 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(ph == 2));
        if (ph == 1) begin
            chk("pcpi_insn", pcpi_insn, e_insn);
            chk("pcpi_rs1", pcpi_rs1, e_rs1);
            chk("pcpi_rs2", pcpi_rs2, e_rs2);
            chk("pcpi_rs3", pcpi_rs3, e_rs3);
        end
        if (ph == 2) begin
            chk("rsp_rd", rsp_rd, e_rd);
            chk("rsp_wr", 32'(rsp_wr), 32'(e_wr));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
            chk("rsp_cycles", 32'(rsp_cycles), 32'(e_cyc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] insn, rs1, rs2, rs3);
        req_valid = 1'b1;
        {req_insn, req_rs1, req_rs2, req_rs3} = {insn, rs1, rs2, rs3};
        tick();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input logic wr);
        pcpi_ready = 1'b1; pcpi_rd = rd; pcpi_wr = wr;
        tick();
        pcpi_ready = 1'b0; pcpi_rd = 32'hBAD0BAD0; pcpi_wr = 1'b1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        en = 1'b1;
        at_neg();
        chk("req_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        at_neg();
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_pcpi_insn", pcpi_insn, 32'd0);
        chk("reset_rsp_rd", rsp_rd, 32'd0);
        chk("reset_rsp_cycles", 32'(rsp_cycles), 32'd0);

        // CLMUL, responder answers one cycle after valid
        send(32'h0A2090B3, 32'h3, 32'h5, 32'h0);
        at_neg();
        chk("clmul_pv1", 32'(pcpi_valid), 32'd1);
        chk("clmul_insn", pcpi_insn, 32'h0A2090B3);
        tick();
        at_neg();
        chk("clmul_pv2", 32'(pcpi_valid), 32'd1);
        respond(32'h0000000F, 1'b1);
        at_neg();
        chk("clmul_pv_off", 32'(pcpi_valid), 32'd0);
        chk("clmul_rd", rsp_rd, 32'h0000000F);
        chk("clmul_wr", 32'(rsp_wr), 32'd1);
        chk("clmul_to", 32'(rsp_timeout), 32'd0);
        chk("clmul_cycles", 32'(rsp_cycles), 32'd2);
        drain();

        // long wait then ready
        send(32'h00000033, 32'h11, 32'h22, 32'h33);
        pcpi_wait = 1'b1;
        repeat (40) tick();
        pcpi_wait = 1'b0;
        respond(32'h12345678, 1'b1);
        at_neg();
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wait_rd", rsp_rd, 32'h12345678);
        chk("wait_to", 32'(rsp_timeout), 32'd0);
        chk("wait_cycles", 32'(rsp_cycles), 32'd41);
        drain();

        // no responder
        send(32'hFFFFFFFF, 32'h1, 32'h2, 32'h3);
`ifdef RVB_PCPI_MASTER_TIMEOUT_EN
        repeat (15) tick();
        at_neg();
        chk("to_still_issue", 32'(pcpi_valid), 32'd1);
        tick();
        at_neg();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_rd", rsp_rd, 32'd0);
        chk("to_wr", 32'(rsp_wr), 32'd0);
        chk("to_cycles", 32'(rsp_cycles), 32'd16);
        drain();
`else
        repeat (1000) tick();
        at_neg();
        chk("noto_still_issue", 32'(pcpi_valid), 32'd1);
        chk("noto_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        // ready in the 16th issue cycle
        send(32'h0000100B, 32'h4, 32'h5, 32'h6);
        repeat (15) tick();
        respond(32'hDEADBEEF, 1'b1);
        at_neg();
        chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("edge_to", 32'(rsp_timeout), 32'd0);
        chk("edge_rd", rsp_rd, 32'hDEADBEEF);
        chk("edge_cycles", 32'(rsp_cycles), 32'd16);
        drain();

        // held response with a back-to-back request waiting
        send(32'h00000001, 32'hA, 32'hB, 32'hC);
        respond(32'h000000A5, 1'b0);
        at_neg();
        chk("min_lat_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("min_lat_cycles", 32'(rsp_cycles), 32'd1);
        req_valid = 1'b1;
        {req_insn, req_rs1, req_rs2, req_rs3} = {32'h00000002, 32'hD, 32'hE, 32'hF};
        repeat (10) tick();
        at_neg();
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        chk("hold_rd", rsp_rd, 32'h000000A5);
        chk("hold_wr", 32'(rsp_wr), 32'd0);
        drain();
        at_neg();
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        at_neg();
        chk("b2b_pv", 32'(pcpi_valid), 32'd1);
        chk("b2b_insn", pcpi_insn, 32'h00000002);
        chk("b2b_rs1", pcpi_rs1, 32'hD);
        respond(32'h00000077, 1'b1);
        drain();

        // reset during the 5th issue cycle, with a result arriving at the same edge
        send(32'h00000005, 32'h1, 32'h1, 32'h1);
        repeat (4) tick();
        reset = 1'b1;
        pcpi_ready = 1'b1; pcpi_rd = 32'hCAFEF00D; pcpi_wr = 1'b1;
        tick();
        pcpi_ready = 1'b0;
        at_neg();
        chk("rst_pv", 32'(pcpi_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'd0);
        tick();
        reset = 1'b0;
        at_neg();
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (5) tick();
        at_neg();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rvb_pcpi_master.md
# rvb_pcpi_master

Initiator side of the PCPI coprocessor interface used by `rvb_pcpi`. It accepts decoded-instruction requests (insn plus three source operands) on a valid/ready port and drives one PCPI transaction at a time. It returns rd, the write-enable and a timeout flag on a response port. It sits between a core's execute stage, or a test sequencer, and any `rvb_pcpi` responder.

## Interface
- `TIMEOUT`, 16: cycles the master waits for `pcpi_wait` or `pcpi_ready` before abandoning the transaction; must be 2..255.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: master can accept a request.
- `req_insn` in 32: instruction word.
- `req_rs1`, `req_rs2`, `req_rs3` in 32 each: source operands.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rd` out 32: result from the responder; 0 on timeout.
- `rsp_wr` out 1: responder requests a register write; 0 on timeout.
- `rsp_timeout` out 1: no responder claimed the instruction.
- `rsp_cycles` out 8: cycles `pcpi_valid` was high for this transaction; saturates at 255.
- `pcpi_valid` out 1: PCPI request valid.
- `pcpi_insn`, `pcpi_rs1`, `pcpi_rs2`, `pcpi_rs3` out 32 each: PCPI request payload.
- `pcpi_wr` in 1: PCPI write-enable from the responder.
- `pcpi_rd` in 32: PCPI result.
- `pcpi_wait` in 1: responder has claimed the instruction and needs more cycles.
- `pcpi_ready` in 1: PCPI result valid.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ISSUE: `pcpi_valid`=1.
  - RESP: `rsp_valid`=1.
- IDLE→ISSUE on `req_valid`&&`req_ready`. Payload is registered into `pcpi_*` and held constant until ISSUE exits. The cycle counter is cleared.
- ISSUE→RESP when `pcpi_ready` is sampled high:
  - Capture `pcpi_rd` and `pcpi_wr`.
  - `rsp_timeout`=0.
- ISSUE→RESP on timeout:
  - `rsp_rd`=0, `rsp_wr`=0, `rsp_timeout`=1.
- RESP→IDLE on `rsp_valid`&&`rsp_ready`.
- Only one transaction is ever outstanding. `req_ready` is 0 in ISSUE and RESP; there is no bypass from RESP to ISSUE.
- `pcpi_wait` sampled high in ISSUE sets a sticky `claimed` bit. Once `claimed` is set, the timeout is disabled and the master waits indefinitely for `pcpi_ready`.
- `pcpi_ready`, `pcpi_wait`, `pcpi_rd` and `pcpi_wr` are ignored outside ISSUE.
- `rsp_cycles` counts ISSUE cycles including the one in which `pcpi_ready` is sampled. It saturates at 255 and does not wrap.

## Timing
- Reset values:
  - State is IDLE.
  - `req_ready`=1 on the cycle after reset is released; it is 0 while `reset` is high.
  - `pcpi_valid`=0, `rsp_valid`=0.
  - All data outputs are 0.
  - `claimed`=0, counter=0.
- Request accepted at edge N → `pcpi_valid` is high from N+1.
- `pcpi_ready` sampled at edge M → `pcpi_valid` is low and `rsp_valid` is high from M+1.
- Minimum request-to-response latency is 2 cycles.
- Timeout fires at the edge ending the `TIMEOUT`-th ISSUE cycle with `claimed`=0 and `pcpi_ready`=0.
- Simultaneous `pcpi_ready` and timeout expiry: ready wins and the result is captured.
- Simultaneous `pcpi_wait` and timeout expiry, without ready: the wait wins, `claimed` is set and there is no timeout.
- `rsp_*` outputs are held stable while `rsp_valid`&&!`rsp_ready`.
- Reset mid-transaction: on the next edge, return to IDLE and drop `pcpi_valid` and `rsp_valid`. Any pending result is discarded.

## Configuration
- `RVB_PCPI_MASTER_TIMEOUT_EN` defined: timeout logic as described above.
- `RVB_PCPI_MASTER_TIMEOUT_EN` undefined:
  - No timeout counter comparison; the master waits forever for `pcpi_ready`.
  - `rsp_timeout` is tied to 0.
  - `claimed` logic is removed.
  - `rsp_cycles` is still counted.

## Structure
- Shared package `rvb_pcpi_pkg`:
  - State enum (IDLE, ISSUE, RESP).
  - Packed request struct (insn, rs1, rs2, rs3).
  - Packed response struct (rd, wr, timeout, cycles).
  - Constant for the `rsp_cycles` width (8).
- No sub-module. The FSM, counter and payload registers live in one module.

## Test plan
- CLMUL `req_insn`=0x0A2090B3, rs1=0x00000003, rs2=0x00000005; responder model returns ready one cycle after valid with rd=0x0000000F, wr=1 → `rsp_rd`=0x0000000F, `rsp_wr`=1, `rsp_timeout`=0, `rsp_cycles`=2, `pcpi_valid` high for exactly 2 cycles.
- Responder asserts wait for 40 cycles, then ready with rd=0x12345678 (TIMEOUT=16, macro on) → no timeout, `rsp_rd`=0x12345678, `rsp_cycles`=41.
- No responder (wait=ready=0), TIMEOUT=16, macro on → `rsp_timeout`=1, `rsp_rd`=0, `rsp_wr`=0, `rsp_cycles`=16; with macro off, still in ISSUE after 1000 cycles.
- Ready asserted in the 16th ISSUE cycle with rd=0xDEADBEEF → `rsp_timeout`=0, `rsp_rd`=0xDEADBEEF.
- `rsp_ready` held low for 10 cycles with back-to-back `req_valid` → `req_ready` stays 0 and `rsp_*` stay stable; the second request is issued 1 cycle after the response handshake.
- `reset` pulsed during ISSUE at cycle 5 → next cycle `pcpi_valid`=0, `rsp_valid`=0, `req_ready`=0 while reset is high and 1 after release; the old result never appears.
